// File: rtl/rgb_pwm_fader.sv
// N-channel LED PWM generator with per-channel static, blink, breathe and off effects.
// Duty changes only on frame boundaries so the LED driver never sees a runt pulse.
module rgb_pwm_fader #(
  parameter int CHANNELS  = 3,
  parameter int PWM_BITS  = 8,
  parameter int STEP_DIV  = 4,
  parameter int CHAN_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [CHAN_BITS-1:0] cfg_chan,
  input  logic [1:0]           cfg_mode,
  input  logic [PWM_BITS-1:0]  cfg_level,
  output logic [CHANNELS-1:0]  pwm_out,
  output logic                 frame_strobe
);

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_OFF     = 2'd3
  } mode_e;

  localparam int TICK_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [CHANNELS-1:0] pwm_out_q, pwm_out_d;
  logic                frame_strobe_q, frame_strobe_d;

  mode_e               mode_q  [CHANNELS];
  mode_e               mode_d  [CHANNELS];
  logic [PWM_BITS-1:0] level_q [CHANNELS];
  logic [PWM_BITS-1:0] level_d [CHANNELS];
  logic [PWM_BITS-1:0] duty_q  [CHANNELS];
  logic [PWM_BITS-1:0] duty_d  [CHANNELS];
  logic [PWM_BITS-1:0] ramp_q  [CHANNELS];
  logic [PWM_BITS-1:0] ramp_d  [CHANNELS];
  logic [PWM_BITS-1:0] eff_duty [CHANNELS];
  logic [CHANNELS-1:0] dir_down_q, dir_down_d;
  logic [CHANNELS-1:0] phase_q, phase_d;

  logic wrap;
  logic tick;
  logic wr_valid;

  assign wrap     = (pwm_cnt_q == '1);
  assign tick     = wrap && (tick_cnt_q == TICK_W'(STEP_DIV - 1));
  assign wr_valid = cfg_we && ({1'b0, cfg_chan} < (CHAN_BITS + 1)'(CHANNELS));

  assign pwm_out      = pwm_out_q;
  assign frame_strobe = frame_strobe_q;

  always_comb begin
    pwm_cnt_d      = pwm_cnt_q + PWM_BITS'(1);
    frame_strobe_d = wrap;
    tick_cnt_d     = tick_cnt_q;
    if (wrap) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    end
  end

  // A config write to a channel takes priority over that channel's effect tick.
  always_comb begin
    pwm_out_d  = '0;
    dir_down_d = dir_down_q;
    phase_d    = phase_q;
    for (int c = 0; c < CHANNELS; c++) begin
      mode_d[c]   = mode_q[c];
      level_d[c]  = level_q[c];
      duty_d[c]   = duty_q[c];
      ramp_d[c]   = ramp_q[c];
      eff_duty[c] = '0;

      case (mode_q[c])
        MODE_STATIC:  eff_duty[c] = level_q[c];
        MODE_BLINK:   eff_duty[c] = phase_q[c] ? level_q[c] : '0;
        MODE_BREATHE: eff_duty[c] = ramp_q[c];
        default:      eff_duty[c] = '0;
      endcase

      pwm_out_d[c] = (pwm_cnt_q < duty_q[c]);
      if (wrap) begin
        duty_d[c] = eff_duty[c];
      end

      if (wr_valid && (cfg_chan == CHAN_BITS'(c))) begin
        mode_d[c]     = mode_e'(cfg_mode);
        level_d[c]    = cfg_level;
        ramp_d[c]     = '0;
        dir_down_d[c] = 1'b0;
        phase_d[c]    = 1'b1;
      end else if (tick) begin
        if (mode_q[c] == MODE_BLINK) begin
          phase_d[c] = ~phase_q[c];
        end else if (mode_q[c] == MODE_BREATHE) begin
          if (!dir_down_q[c]) begin
            if (ramp_q[c] < level_q[c]) begin
              ramp_d[c] = ramp_q[c] + PWM_BITS'(1);
            end else begin
              dir_down_d[c] = 1'b1;
              if (ramp_q[c] != '0) ramp_d[c] = ramp_q[c] - PWM_BITS'(1);
            end
          end else begin
            if (ramp_q[c] != '0) begin
              ramp_d[c] = ramp_q[c] - PWM_BITS'(1);
            end else begin
              dir_down_d[c] = 1'b0;
              if (level_q[c] != '0) ramp_d[c] = ramp_q[c] + PWM_BITS'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q      <= '0;
      tick_cnt_q     <= '0;
      pwm_out_q      <= '0;
      frame_strobe_q <= 1'b0;
      dir_down_q     <= '0;
      phase_q        <= '1;
      for (int c = 0; c < CHANNELS; c++) begin
        mode_q[c]  <= MODE_STATIC;
        level_q[c] <= '0;
        duty_q[c]  <= '0;
        ramp_q[c]  <= '0;
      end
    end else begin
      pwm_cnt_q      <= pwm_cnt_d;
      tick_cnt_q     <= tick_cnt_d;
      pwm_out_q      <= pwm_out_d;
      frame_strobe_q <= frame_strobe_d;
      dir_down_q     <= dir_down_d;
      phase_q        <= phase_d;
      for (int c = 0; c < CHANNELS; c++) begin
        mode_q[c]  <= mode_d[c];
        level_q[c] <= level_d[c];
        duty_q[c]  <= duty_d[c];
        ramp_q[c]  <= ramp_d[c];
      end
    end
  end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed frame-by-frame bench for rgb_pwm_fader with 4-bit PWM, one frame per tick.
// Each captured frame is compared against per-channel expected waveforms queued beforehand.
module tb_rgb_pwm_fader;

  localparam int CH = 3;
  localparam int PB = 4;
  localparam int SD = 1;
  localparam int CB = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_we = 1'b0;
  logic [CB-1:0] cfg_chan = '0;
  logic [1:0]    cfg_mode = '0;
  logic [PB-1:0] cfg_level = '0;
  logic [CH-1:0] pwm_out;
  logic          frame_strobe;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    int          chan;
    logic [15:0] pat;
  } expEntry;

  expEntry     scoreboard[$];
  logic [15:0] capPwm [CH];
  logic [15:0] capStrobe;

  int          wrAt = -1;
  logic [CB-1:0] wrChan = '0;
  logic [1:0]    wrMode = '0;
  logic [PB-1:0] wrLevel = '0;

  rgb_pwm_fader #(
    .CHANNELS (CH),
    .PWM_BITS (PB),
    .STEP_DIV (SD),
    .CHAN_BITS(CB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_chan    (cfg_chan),
    .cfg_mode    (cfg_mode),
    .cfg_level   (cfg_level),
    .pwm_out     (pwm_out),
    .frame_strobe(frame_strobe)
  );

  always #5 clk = ~clk;

  // Window starts on the frame_strobe cycle; duty d shows as offsets 1..d high.
  function automatic logic [15:0] dutyPat(int d);
    logic [15:0] p;
    p = '0;
    for (int i = 1; i < 16; i++) begin
      if (i <= d) p[i] = 1'b1;
    end
    return p;
  endfunction

  function automatic int blinkDuty(int n);
    return (n % 2 == 0) ? 15 : 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int at, input int chan, input int mode, input int level);
    wrAt    = at;
    wrChan  = CB'(chan);
    wrMode  = 2'(mode);
    wrLevel = PB'(level);
  endtask

  task automatic expectFrame(input string tag, input int d0, input int d1, input int d2);
    int d [CH];
    expEntry e;
    d[0] = d0;
    d[1] = d1;
    d[2] = d2;
    for (int c = 0; c < CH; c++) begin
      e.tag  = $sformatf("%s_ch%0d", tag, c);
      e.chan = c;
      e.pat  = dutyPat(d[c]);
      scoreboard.push_back(e);
    end
  endtask

  // Must be entered on the negedge where frame_strobe is high; leaves on the next one.
  task automatic captureFrame();
    expEntry e;
    for (int i = 0; i < 16; i++) begin
      if (i == wrAt) begin
        cfg_we    = 1'b1;
        cfg_chan  = wrChan;
        cfg_mode  = wrMode;
        cfg_level = wrLevel;
      end else begin
        cfg_we = 1'b0;
      end
      for (int c = 0; c < CH; c++) capPwm[c][i] = pwm_out[c];
      capStrobe[i] = frame_strobe;
      @(negedge clk);
    end
    cfg_we = 1'b0;
    wrAt   = -1;
    checkOutput("strobe_pattern", capStrobe, 16'h0001);
    for (int k = 0; k < CH; k++) begin
      if (scoreboard.size() == 0) begin
        checkOutput("scoreboard_empty", 16'd0, 16'd1);
      end else begin
        e = scoreboard.pop_front();
        checkOutput(e.tag, capPwm[e.chan], e.pat);
      end
    end
  endtask

  task automatic waitStrobe(input string tag, input int expCycles);
    int n;
    n = 0;
    while (frame_strobe !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 16'(n), 16'(expCycles));
  endtask

  initial begin
    int breathe [10];
    breathe = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3};

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_pwm", 16'(pwm_out), 16'd0);
    checkOutput("reset_strobe", 16'(frame_strobe), 16'd0);
    rst = 1'b0;
    waitStrobe("first_strobe", 16);

    // Idle: outputs stay low, strobe once per 16 cycles.
    for (int f = 0; f < 4; f++) begin
      expectFrame("idle", 0, 0, 0);
      captureFrame();
    end

    // Static levels on channel 1.
    applyStimulus(3, 1, 0, 5);
    expectFrame("static5_cur", 0, 0, 0);
    captureFrame();
    applyStimulus(3, 1, 0, 15);
    expectFrame("static5", 0, 5, 0);
    captureFrame();
    applyStimulus(3, 1, 0, 0);
    expectFrame("static15", 0, 15, 0);
    captureFrame();
    expectFrame("static0", 0, 0, 0);
    captureFrame();

    // Blink on channel 0, breathe on channel 2.
    applyStimulus(3, 0, 1, 15);
    expectFrame("blink_cur", 0, 0, 0);
    captureFrame();
    applyStimulus(3, 2, 2, 3);
    expectFrame("blink_first", blinkDuty(0), 0, 0);
    captureFrame();
    for (int k = 0; k < 10; k++) begin
      expectFrame($sformatf("breathe%0d", k), blinkDuty(k + 1), 0, breathe[k]);
      captureFrame();
    end
    applyStimulus(3, 2, 2, 0);
    expectFrame("breathe_l0_cur", blinkDuty(11), 0, 2);
    captureFrame();
    for (int n = 12; n < 15; n++) begin
      expectFrame($sformatf("breathe_l0_%0d", n), blinkDuty(n), 0, 0);
      captureFrame();
    end

    // Write on the wrap edge: next frame keeps the old effective duty.
    applyStimulus(15, 0, 0, 8);
    expectFrame("wrap_wr_cur", blinkDuty(15), 0, 0);
    captureFrame();
    expectFrame("wrap_wr_old", blinkDuty(16), 0, 0);
    captureFrame();
    applyStimulus(3, 3, 0, 15);
    expectFrame("wrap_wr_new", 8, 0, 0);
    captureFrame();
    applyStimulus(3, 2, 2, 3);
    expectFrame("bad_chan", 8, 0, 0);
    captureFrame();

    // Write to a breathing channel on the tick edge restarts the ramp.
    expectFrame("rb0", 8, 0, 0);
    captureFrame();
    expectFrame("rb1", 8, 0, 1);
    captureFrame();
    applyStimulus(15, 2, 2, 3);
    expectFrame("rb2", 8, 0, 2);
    captureFrame();
    expectFrame("rb_old", 8, 0, 3);
    captureFrame();
    expectFrame("rb_restart0", 8, 0, 0);
    captureFrame();
    expectFrame("rb_restart1", 8, 0, 1);
    captureFrame();
    expectFrame("rb_restart2", 8, 0, 2);
    captureFrame();

    // All channels full on, then asynchronous reset mid-frame.
    applyStimulus(3, 1, 0, 15);
    expectFrame("full_a", 8, 0, 3);
    captureFrame();
    applyStimulus(3, 2, 0, 15);
    expectFrame("full_b", 8, 15, 2);
    captureFrame();
    applyStimulus(3, 0, 0, 15);
    expectFrame("full_c", 8, 15, 15);
    captureFrame();
    expectFrame("full_d", 15, 15, 15);
    captureFrame();
    repeat (7) @(negedge clk);
    checkOutput("pre_reset_pwm", 16'(pwm_out), 16'h0007);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_reset_pwm", 16'(pwm_out), 16'd0);
    checkOutput("async_reset_strobe", 16'(frame_strobe), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    waitStrobe("post_reset_strobe", 16);
    expectFrame("post_reset", 0, 0, 0);
    captureFrame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_fader.md
Name: rgb_pwm_fader

Overview:
- Parametrised N-channel LED PWM generator with per-channel level and effect mode: static, blink, breathe, off.
- Replaces ad-hoc counter-bit LED drive in projects.
- pwm_out feeds the RGBxPWM inputs of the SB_RGBA_DRV current-limited driver.
- Configured by a simple single-cycle write port from a host/SPI register block.

Parameters:
CHANNELS, 3, number of LED channels (>=1)
PWM_BITS, 8, PWM resolution; frame = 2^PWM_BITS clk cycles
STEP_DIV, 4, frames per effect tick (>=1)
CHAN_BITS, 2, width of cfg_chan (>= clog2(CHANNELS), min 1)

Ports:
clk  input  1  system clock (12 MHz oscillator)
rst  input  1  asynchronous active-high reset
cfg_we  input  1  config write strobe, single cycle
cfg_chan  input  CHAN_BITS  target channel
cfg_mode  input  2  0 STATIC, 1 BLINK, 2 BREATHE, 3 OFF
cfg_level  input  PWM_BITS  peak duty level
pwm_out  output  CHANNELS  registered PWM, bit c = channel c
frame_strobe  output  1  high one cycle per frame, on the wrap cycle

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous, active-high. All state is cleared asynchronously on rst.
- Reset values:
  - pwm_cnt=0, tick_cnt=0, pwm_out=0, frame_strobe=0.
  - Per channel: mode=STATIC, level=0, duty_active=0, ramp=0, dir=up, phase=1.
- pwm_cnt: PWM_BITS-bit free-running counter, +1 every clk, wraps max->0.
- wrap edge: the clock edge on which pwm_cnt==2^PWM_BITS-1. frame_strobe is the registered form of this condition and is high the cycle after.
- Output compare: pwm_out[c] <= (pwm_cnt < duty_active[c]). Output lags the counter by 1 cycle.
  - level 0: constant low.
  - level max: high 2^PWM_BITS-1 of 2^PWM_BITS cycles.
- Glitch-free update: duty_active[c] loads only on the wrap edge, from the pre-edge effective duty:
  - STATIC: level.
  - BLINK: phase ? level : 0.
  - BREATHE: ramp.
  - OFF: 0.
- Effect tick:
  - tick_cnt counts wrap edges 0..STEP_DIV-1.
  - tick fires on the wrap edge where tick_cnt==STEP_DIV-1; tick_cnt then returns to 0.
  - Per-channel effect state updates on that same edge, so it is visible in duty_active one frame later.
- BLINK: phase toggles each tick. Period = 2*STEP_DIV frames.
- BREATHE, on tick:
  - up & ramp<level: ramp+1.
  - up & ramp>=level: dir=down; ramp-1 if ramp>0, else hold.
  - down & ramp>0: ramp-1.
  - down & ramp==0: dir=up; ramp+1 if level>0, else hold.
  - Triangle 0..level..0, period 2*level ticks. level 0 stays at 0.
- STATIC/OFF: ramp, dir and phase hold.
- Config write, when cfg_we and cfg_chan<CHANNELS:
  - Next edge: mode=cfg_mode, level=cfg_level, ramp=0, dir=up, phase=1.
  - cfg_chan>=CHANNELS: write ignored, no state change.
- Simultaneous events:
  - Write and tick on the same channel, same edge: the write wins and the tick is lost for that channel only.
  - Write on the wrap edge: duty_active takes the old effective value; the new config applies from the following frame.
- Latency: a write in a non-wrap cycle appears on pwm_out in the next frame, starting 1 cycle after pwm_cnt reaches 0.
- Reset mid-frame: outputs go low immediately (asynchronous). After release, the counter restarts from 0.

Test Plan:
Use PWM_BITS=4, STEP_DIV=1, CHANNELS=3 unless stated.
1. Reset released, no writes -> pwm_out=000 for 64 cycles; frame_strobe high exactly every 16 cycles.
2. Write ch1 STATIC level 5 at pwm_cnt=3:
   - Current frame: pwm_out[1] stays 0.
   - Next frame: pwm_out[1] high exactly 5 consecutive cycles, starting 1 cycle after pwm_cnt=0.
   - level 15 -> high 15 of 16; level 0 -> never high.
3. Write ch0 BLINK level 15 -> pwm_out[0] duty alternates 15/16 and 0/16 on successive frames; first effective frame is on.
4. Write ch2 BREATHE level 3 -> per-frame high-cycle counts from first effective frame: 0,1,2,3,2,1,0,1,2,3,...
   - With level 0 -> all zeros.
5. Boundary writes:
   - Write ch0 STATIC 8 on the wrap edge -> the next frame keeps the old duty; 8 applies one frame later.
   - cfg_chan=3 -> no channel changes.
   - Write on a tick edge to a BREATHE channel -> ramp restarts at 0.
6. Assert rst mid-frame with all channels STATIC 15 -> pwm_out=000 in the same cycle (asynchronous).
   - After release: pwm_out=000 (levels reset), pwm_cnt restarts at 0, first frame_strobe 16 cycles later.
